// File: rtl/ides_word_align.sv
// Comma-hunting word aligner for the IDES16 deserializer, running in its PCLK domain.
// Define IDES_ALIGN_RD_BOTH_EN to accept the K28.5 comma in either running disparity.
module ides_word_align #(
    parameter logic [9:0] COMMA        = 10'b0011111010,
    parameter int         COMMA_WINDOW = 16,
    parameter int         LOCK_COUNT   = 4,
    parameter int         LOSS_COUNT   = 2,
    parameter int         SLIP_WAIT    = 3
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [9:0] data_i,
    output logic       calib_o,
    output logic [9:0] word_o,
    output logic       word_vld_o,
    output logic       comma_o,
    output logic       locked_o,
    output logic [3:0] slip_cnt_o
);

    localparam int WIN_W  = $clog2(COMMA_WINDOW) + 1;
    localparam int GOOD_W = $clog2(LOCK_COUNT) + 1;
    localparam int MISS_W = $clog2(LOSS_COUNT) + 1;
    localparam int WAIT_W = $clog2(SLIP_WAIT) + 1;

    localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(COMMA_WINDOW - 1);
    localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_COUNT - 1);
    localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(LOSS_COUNT - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SLIP_WAIT - 1);

    typedef enum logic [1:0] {
        HUNT,
        WAIT,
        LOCKED
    } state_t;

    state_t            state_q;
    logic [9:0]        word_q;
    logic              calib_q;
    logic              locked_q;
    logic [3:0]        slipCnt_q;
    logic [WIN_W-1:0]  winCnt_q;
    logic [GOOD_W-1:0] goodCnt_q;
    logic [MISS_W-1:0] missCnt_q;
    logic [WAIT_W-1:0] waitCnt_q;
    logic              commaMatch;

`ifdef IDES_ALIGN_RD_BOTH_EN
    assign commaMatch = (word_q == COMMA) || (word_q == ~COMMA);
`else
    assign commaMatch = (word_q == COMMA);
`endif

    // Decisions act on the registered word, so every output lags the comma by one edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= HUNT;
            word_q    <= '0;
            calib_q   <= 1'b0;
            locked_q  <= 1'b0;
            slipCnt_q <= '0;
            winCnt_q  <= '0;
            goodCnt_q <= '0;
            missCnt_q <= '0;
            waitCnt_q <= '0;
        end else begin
            word_q  <= data_i;
            calib_q <= 1'b0;
            case (state_q)
                HUNT: begin
                    if (commaMatch) begin
                        winCnt_q  <= '0;
                        goodCnt_q <= goodCnt_q + 1'b1;
                        if (goodCnt_q == GOOD_LAST) begin
                            state_q   <= LOCKED;
                            locked_q  <= 1'b1;
                            missCnt_q <= '0;
                        end
                    end else if (winCnt_q == WIN_LAST) begin
                        calib_q   <= 1'b1;
                        slipCnt_q <= slipCnt_q + 4'd1;
                        goodCnt_q <= '0;
                        waitCnt_q <= '0;
                        state_q   <= WAIT;
                    end else begin
                        winCnt_q <= winCnt_q + 1'b1;
                    end
                end
                WAIT: begin
                    if (waitCnt_q == WAIT_LAST) begin
                        winCnt_q <= '0;
                        state_q  <= HUNT;
                    end else begin
                        waitCnt_q <= waitCnt_q + 1'b1;
                    end
                end
                LOCKED: begin
                    if (commaMatch) begin
                        winCnt_q  <= '0;
                        missCnt_q <= '0;
                    end else if (winCnt_q == WIN_LAST) begin
                        winCnt_q  <= '0;
                        missCnt_q <= missCnt_q + 1'b1;
                        // Losing lock goes straight back to hunting; the boundary may still be right.
                        if (missCnt_q == MISS_LAST) begin
                            state_q   <= HUNT;
                            locked_q  <= 1'b0;
                            goodCnt_q <= '0;
                        end
                    end else begin
                        winCnt_q <= winCnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q  <= HUNT;
                    locked_q <= 1'b0;
                    winCnt_q <= '0;
                end
            endcase
        end
    end

    assign word_o     = word_q;
    assign calib_o    = calib_q;
    assign locked_o   = locked_q;
    assign word_vld_o = locked_q;
    assign comma_o    = commaMatch;
    assign slip_cnt_o = slipCnt_q;

endmodule

// File: tb/tb_ides_word_align.sv
// Self-checking bench for ides_word_align: per-cycle comparison against a behavioural
// aligner model, plus hand-derived timing expectations for lock, slip, loss and wrap.
module tb_ides_word_align;

    localparam logic [9:0] COMMA  = 10'b0011111010;
    localparam int         WINDOW = 16;
    localparam int         SETTLE = 3;

    logic       clk_i  = 1'b0;
    logic       rst_i  = 1'b1;
    logic [9:0] data_i = '0;
    logic       calib_o;
    logic [9:0] word_o;
    logic       word_vld_o;
    logic       comma_o;
    logic       locked_o;
    logic [3:0] slip_cnt_o;

    ides_word_align dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .data_i     (data_i),
        .calib_o    (calib_o),
        .word_o     (word_o),
        .word_vld_o (word_vld_o),
        .comma_o    (comma_o),
        .locked_o   (locked_o),
        .slip_cnt_o (slip_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;

    // Behavioural model: a flag for lock, a settle countdown, and running tallies.
    logic [9:0] mWord;
    bit         mCalib;
    bit         mLocked;
    logic [3:0] mSlips;
    int         mRun;
    int         mCommas;
    int         mMisses;
    int         mSettle;

    int  cycle;
    int  calibCycles[$];
    int  lockRiseCycle;
    int  lockFallCycle;
    int  commaSeenCycle;
    int  comma305Count;
    bit  prevCalib;
    bit  prevLocked;

    function automatic bit isComma(input logic [9:0] w);
`ifdef IDES_ALIGN_RD_BOTH_EN
        return (w == COMMA) || (w == ~COMMA);
`else
        return w == COMMA;
`endif
    endfunction

    function automatic logic [9:0] randData();
        logic [9:0] d;
        d = 10'($urandom);
        if (d == COMMA || d == ~COMMA) d = 10'h155;
        return d;
    endfunction

    task automatic modelReset();
        mWord   = '0;
        mCalib  = 1'b0;
        mLocked = 1'b0;
        mSlips  = '0;
        mRun    = 0;
        mCommas = 0;
        mMisses = 0;
        mSettle = 0;
    endtask

    task automatic modelStep(input logic [9:0] d);
        mCalib = 1'b0;
        if (mSettle > 0) begin
            mSettle = mSettle - 1;
            if (mSettle == 0) mRun = 0;
        end else if (isComma(mWord)) begin
            mRun = 0;
            if (mLocked) begin
                mMisses = 0;
            end else begin
                mCommas = mCommas + 1;
                if (mCommas == 4) begin
                    mLocked = 1'b1;
                    mMisses = 0;
                end
            end
        end else if (mRun == WINDOW - 1) begin
            mRun = 0;
            if (mLocked) begin
                mMisses = mMisses + 1;
                if (mMisses == 2) begin
                    mLocked = 1'b0;
                    mCommas = 0;
                end
            end else begin
                mCalib  = 1'b1;
                mSlips  = mSlips + 4'd1;
                mCommas = 0;
                mSettle = SETTLE;
            end
        end else begin
            mRun = mRun + 1;
        end
        mWord = d;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cycle);
        end
    endtask

    // Compare process: sample the input at the edge, advance the model, check 1 unit later.
    always @(posedge clk_i) begin : compare
        logic [9:0] sampled;
        sampled = data_i;
        #1;
        if (rst_i) begin
            modelReset();
            cycle          = 0;
            calibCycles    = {};
            lockRiseCycle  = -1;
            lockFallCycle  = -1;
            commaSeenCycle = -1;
            comma305Count  = 0;
            prevCalib      = 1'b0;
            prevLocked     = 1'b0;
        end else begin
            cycle++;
            modelStep(sampled);
        end
        checkOutput("word_o", word_o, mWord);
        checkOutput("comma_o", comma_o, isComma(mWord));
        checkOutput("calib_o", calib_o, mCalib);
        checkOutput("locked_o", locked_o, mLocked);
        checkOutput("word_vld_o", word_vld_o, mLocked);
        checkOutput("slip_cnt_o", slip_cnt_o, mSlips);
        if (!rst_i) begin
            if (calib_o) begin
                checkOutput("calib_back_to_back", prevCalib, 1'b0);
                if (calibCycles.size() > 0)
                    checkOutput("calib_spacing", (cycle - calibCycles[$]) >= (SETTLE + WINDOW), 1'b1);
                calibCycles.push_back(cycle);
            end
            if (locked_o && !prevLocked) lockRiseCycle = cycle;
            if (!locked_o && prevLocked) lockFallCycle = cycle;
            if (comma_o) commaSeenCycle = cycle;
            if (comma_o && word_o == 10'h305) comma305Count++;
            prevCalib  = calib_o;
            prevLocked = locked_o;
        end
    end

    task automatic applyStimulus(input logic [9:0] d);
        data_i = d;
        @(posedge clk_i);
        #2;
    endtask

    task automatic applyReset();
        rst_i = 1'b1;
        #1;
        checkOutput("rst_word_o", word_o, 10'h000);
        checkOutput("rst_calib_o", calib_o, 1'b0);
        checkOutput("rst_comma_o", comma_o, 1'b0);
        checkOutput("rst_locked_o", locked_o, 1'b0);
        checkOutput("rst_word_vld_o", word_vld_o, 1'b0);
        checkOutput("rst_slip_cnt_o", slip_cnt_o, 4'd0);
        @(posedge clk_i);
        #2;
        rst_i = 1'b0;
    endtask

    initial begin
        int c;
        int r;
        @(posedge clk_i);
        #2;
        applyReset();

        // Clean lock: comma every 8th word, 4th comma on word_o at cycle 32.
        for (int j = 0; j < 48; j++) begin
            applyStimulus((j % 8 == 7) ? COMMA : randData());
            if (j == 31) begin
                checkOutput("clean_comma4_visible", comma_o, 1'b1);
                checkOutput("clean_not_locked_yet", locked_o, 1'b0);
            end
            if (j == 32) checkOutput("clean_locked_next", locked_o, 1'b1);
        end
        checkOutput("clean_lock_cycle", lockRiseCycle, 33);
        checkOutput("clean_no_calib", calibCycles.size(), 0);
        checkOutput("clean_slip_cnt", slip_cnt_o, 4'd0);

        // Loss of lock: two comma-free windows after the last comma.
        c = commaSeenCycle;
        for (int j = 0; j < 36; j++) applyStimulus(randData());
        checkOutput("loss_fall_delay", lockFallCycle - c, 33);
        checkOutput("loss_no_calib", calibCycles.size(), 0);
        for (int j = 0; j < 40; j++) begin
            applyStimulus((j % 8 == 7) ? COMMA : randData());
            if (j == 31) checkOutput("relock_not_yet", locked_o, 1'b0);
            if (j == 32) checkOutput("relock_locked", locked_o, 1'b1);
        end

        // Mid-stream reset, then slip sequence with commas landing inside the first settle.
        applyReset();
        for (int k = 1; k <= 54; k++) applyStimulus((k == 17 || k == 18) ? COMMA : randData());
        checkOutput("slip_pulses", calibCycles.size(), 3);
        if (calibCycles.size() == 3) begin
            checkOutput("slip_first_cycle", calibCycles[0], 16);
            checkOutput("slip_second_cycle", calibCycles[1], 35);
            checkOutput("slip_third_cycle", calibCycles[2], 54);
        end
        checkOutput("slip_cnt_3", slip_cnt_o, 4'd3);
        for (int k = 1; k <= 40; k++) applyStimulus((k % 8 == 0) ? COMMA : randData());
        checkOutput("slip_then_locked", locked_o, 1'b1);
        checkOutput("slip_cnt_still_3", slip_cnt_o, 4'd3);

        // Comma exactly on the 16th word of every window.
        applyReset();
        for (int k = 1; k <= 70; k++) applyStimulus((k % 16 == 15) ? COMMA : randData());
        checkOutput("edge16_no_slip", slip_cnt_o, 4'd0);
        checkOutput("edge16_lock_cycle", lockRiseCycle, 64);

        // Alternating running disparity.
        applyReset();
        for (int k = 1; k <= 72; k++)
            applyStimulus((k % 8 == 0) ? (((k / 8) % 2 == 1) ? COMMA : ~COMMA) : randData());
        checkOutput("rd_locked", locked_o, 1'b1);
`ifdef IDES_ALIGN_RD_BOTH_EN
        checkOutput("rd_lock_cycle", lockRiseCycle, 33);
        checkOutput("rd_305_commas", comma305Count, 4);
`else
        checkOutput("rd_lock_cycle", lockRiseCycle, 57);
        checkOutput("rd_305_commas", comma305Count, 0);
`endif

        // slip_cnt_o wraps on the 16th pulse at cycle 16 + 15*19 = 301.
        applyReset();
        for (int k = 1; k <= 300; k++) applyStimulus(randData());
        checkOutput("wrap_before", slip_cnt_o, 4'd15);
        applyStimulus(randData());
        checkOutput("wrap_after", slip_cnt_o, 4'd0);
        checkOutput("wrap_calib", calib_o, 1'b1);

        // Randomized segments: dense commas, silence, sparse commas, with a reset mid-way.
        applyReset();
        for (int k = 0; k < 900; k++) begin
            if (k == 450) applyReset();
            r = $urandom_range(0, 19);
            case ((k / 100) % 3)
                0:       applyStimulus((r < 4) ? COMMA : ((r == 4) ? ~COMMA : randData()));
                1:       applyStimulus((r == 0) ? ~COMMA : randData());
                default: applyStimulus((r == 0) ? COMMA : randData());
            endcase
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ides_word_align.md
# ides_word_align

Word aligner that sits directly downstream of the IDES16 deserializer and runs in its PCLK domain. It takes the 10-bit parallel word each cycle, hunts for an 8b/10b comma, and pulses the deserializer's CALIB (bitslip) input until commas appear at a stable word boundary. Once enough commas have been seen it declares lock and qualifies the word stream to the 8b/10b decoder. It drops lock after repeated comma-free windows.

## Interface
- COMMA, 10'b0011111010, comma pattern in RD- form (K28.5), compared against bit order q[9:0]
- COMMA_WINDOW, 16, words allowed between commas before the window counts as a miss; must be ≥2
- LOCK_COUNT, 4, consecutive in-window commas required to lock; must be ≥1
- LOSS_COUNT, 2, consecutive comma-free windows in LOCKED that drop lock; must be ≥1
- SLIP_WAIT, 3, cycles ignored after a CALIB pulse while the deserializer settles; must be ≥1

- clk_i  in  1  word clock, same net as the deserializer PCLK
- rst_i  in  1  asynchronous, active-high reset
- data_i  in  10  parallel word from the deserializer
- calib_o  out  1  one-cycle bitslip pulse, drives deserializer CALIB
- word_o  out  10  registered copy of data_i
- word_vld_o  out  1  word_o is aligned (equals locked_o)
- comma_o  out  1  word_o matches a comma; combinational from word_o
- locked_o  out  1  aligner in LOCKED
- slip_cnt_o  out  4  CALIB pulses issued since reset, wraps 15→0

## Operation
- Every clock: word_o <= data_i. Detection and all FSM decisions use word_o.
- The comma match compares word_o to COMMA. With the configuration macro, word_o == ~COMMA also matches.
- Counters:
  - win_cnt: words since last comma, or since entering HUNT.
  - good_cnt: commas seen in HUNT.
  - miss_cnt: comma-free windows in LOCKED.
  - wait_cnt: settle counter for WAIT.
- Counter widths are $clog2(param)+1. Counters never wrap except slip_cnt_o.

States:
- HUNT
  - comma: good_cnt+1, win_cnt <= 0. If good_cnt+1 == LOCK_COUNT → LOCKED, miss_cnt <= 0.
  - no comma, win_cnt == COMMA_WINDOW-1: calib_o <= 1, slip_cnt+1, good_cnt <= 0, wait_cnt <= 0 → WAIT.
  - otherwise: win_cnt+1.
- WAIT
  - calib_o <= 0. word_o is ignored; commas do not count.
  - wait_cnt == SLIP_WAIT-1: win_cnt <= 0 → HUNT. Otherwise wait_cnt+1.
- LOCKED
  - comma: win_cnt <= 0, miss_cnt <= 0.
  - no comma, win_cnt == COMMA_WINDOW-1: win_cnt <= 0, miss_cnt+1. If miss_cnt+1 == LOSS_COUNT → HUNT, good_cnt <= 0. No CALIB is issued on loss of lock.
  - otherwise: win_cnt+1.
- A comma on the same cycle as window expiry counts as a comma; no miss or slip is taken.
- calib_o is never asserted in two consecutive cycles. The minimum spacing between pulses is SLIP_WAIT+COMMA_WINDOW cycles.

## Timing
- Reset (async assert, release sync to clk_i): state HUNT, every counter 0, and all outputs 0: word_o, calib_o, comma_o, locked_o, word_vld_o, slip_cnt_o.
- Reset mid-operation returns to this state immediately. An in-flight calib_o pulse is truncated.
- data_i → word_o and comma_o: 1 cycle.
- The LOCK_COUNT-th comma is on word_o at edge n. locked_o and word_vld_o go high at edge n+1. That comma word itself is not marked valid.
- A HUNT window expires at edge n. calib_o is high for exactly the cycle after edge n+1. slip_cnt_o increments at edge n+1.
- A LOSS_COUNT-th miss evaluated at edge n drops locked_o at edge n+1.

## Configuration
- IDES_ALIGN_RD_BOTH_EN defined: the comma match accepts COMMA or ~COMMA, covering both running disparities.
- Undefined: only the exact COMMA matches. ~COMMA is treated as ordinary data, so it advances win_cnt and can cause slips or misses.

## Test plan
- **Reset outputs:** assert rst_i mid-stream for 1 cycle → all outputs 0 on the same cycle; state HUNT.
- **Clean lock:** feed 10'h0FA every 8th word → no calib_o; locked_o rises 1 cycle after the 4th comma appears on word_o; slip_cnt_o=0.
- **Slip sequence:** feed random non-comma data, then commas every 8 words after the 3rd CALIB pulse → exactly 3 calib_o pulses, each 1 cycle, spaced ≥19 cycles; slip_cnt_o=3; lock after 4 commas.
- **Loss of lock:** once locked, stop commas → locked_o falls 1 cycle after the 2nd miss (32 words after the last comma, ±1), no calib_o. Resuming commas relocks after 4.
- **Both disparities:** alternate 10'h0FA and 10'h305 every 8 words → with IDES_ALIGN_RD_BOTH_EN, lock after 4 commas; without it, lock only if four 10'h0FA words fall within windows, and comma_o stays 0 on 10'h305.
- **Edge cases:** comma on exactly the 16th word → no slip or miss. Commas during WAIT → ignored, good_cnt unchanged. slip_cnt_o wraps from 15 to 0 on the 16th pulse.
